controlador_compuerta: RTL and testbench

Parking-gate controller: the design under test that the gate stimulus generator drives. It consumes the vehicle-present, PIN and vehicle-passed inputs and produces the gate status outputs Cerrado, Abierto, Alarma and Bloqueo. Registered Moore FSM with a PIN-entry edge detector and a wrong-attempt counter. Lives beside the gate stimulus generator; together they form the gate testbench.

---
 rtl/controlador_compuerta_pkg.sv | 35 +++
 rtl/detector_pin.sv | 32 +++
 rtl/controlador_compuerta.sv | 108 ++++++++++
 tb/tb_controlador_compuerta.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_compuerta_pkg.sv
// Shared definitions for the parking-gate controller and its stimulus generator:
// state encoding, default PIN constants and the Moore output decode.
package controlador_compuerta_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StEsperaPin = 3'd1,
    StAbierto   = 3'd2,
    StAlarma    = 3'd3,
    StBloqueo   = 3'd4
  } estado_e;

  localparam logic [7:0] PinCorrectoDef = 8'b00001000;
  localparam logic [7:0] PinEsperaDef   = 8'b00000000;

  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
  } salidas_t;

  function automatic salidas_t decodifica(estado_e st);
    salidas_t s;
    s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b0, bloqueo: 1'b0};
    case (st)
      StAbierto: s = '{cerrado: 1'b0, abierto: 1'b1, alarma: 1'b0, bloqueo: 1'b0};
      StAlarma:  s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b1, bloqueo: 1'b0};
      StBloqueo: s = '{cerrado: 1'b1, abierto: 1'b0, alarma: 1'b1, bloqueo: 1'b1};
      default:   ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/detector_pin.sv
// PIN-entry edge detector: one event per idle-to-pressed transition of the keypad,
// classified as correct or wrong against the authorised PIN.
module detector_pin
  import controlador_compuerta_pkg::*;
#(
  parameter logic [7:0] PIN_CORRECTO = PinCorrectoDef,
  parameter logic [7:0] PIN_ESPERA   = PinEsperaDef
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Pin,
  output logic       ev_ok,
  output logic       ev_mal
);

  logic [7:0] pin_prev_q;
  logic       ev_pin;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pin_prev_q <= PIN_ESPERA;
    end else begin
      pin_prev_q <= Pin;
    end
  end

  // Switching between two pressed values without releasing is not a new entry.
  assign ev_pin = (Pin != PIN_ESPERA) && (pin_prev_q == PIN_ESPERA);
  assign ev_ok  = ev_pin && (Pin == PIN_CORRECTO);
  assign ev_mal = ev_pin && (Pin != PIN_CORRECTO);

endmodule

// File: rtl/controlador_compuerta.sv
// Parking-gate controller: registered Moore FSM with a saturating wrong-PIN counter.
// Outputs are registered from the next state so they never glitch.
module controlador_compuerta
  import controlador_compuerta_pkg::*;
#(
  parameter logic [7:0]  PIN_CORRECTO = PinCorrectoDef,
  parameter logic [7:0]  PIN_ESPERA   = PinEsperaDef,
  parameter int unsigned MAX_INTENTOS = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Vehiculo,
  input  logic       Termino,
  input  logic [7:0] Pin,
  output logic       Cerrado,
  output logic       Abierto,
  output logic       Alarma,
  output logic       Bloqueo
);

  localparam logic [1:0] MaxFallos = 2'(MAX_INTENTOS);

  estado_e    state_q, state_d;
  logic [1:0] fallos_q, fallos_d;
  salidas_t   salidas_q;
  logic       ev_ok, ev_mal;

  detector_pin #(
    .PIN_CORRECTO(PIN_CORRECTO),
    .PIN_ESPERA  (PIN_ESPERA)
  ) u_detector_pin (
    .Clk   (Clk),
    .Reset (Reset),
    .Pin   (Pin),
    .ev_ok (ev_ok),
    .ev_mal(ev_mal)
  );

  always_comb begin
    state_d  = state_q;
    fallos_d = fallos_q;
    case (state_q)
      StIdle: begin
        fallos_d = 2'd0;
        if (Vehiculo) state_d = StEsperaPin;
      end
      StEsperaPin: begin
        if (ev_ok) begin
          state_d  = StAbierto;
          fallos_d = 2'd0;
        end else if (ev_mal) begin
          if (fallos_q + 2'd1 >= MaxFallos) begin
            state_d  = StAlarma;
            fallos_d = MaxFallos;
          end else begin
            fallos_d = fallos_q + 2'd1;
          end
        end else if (!Vehiculo) begin
          state_d  = StIdle;
          fallos_d = 2'd0;
        end
      end
      StAlarma: begin
        // The alarm only clears with the correct PIN, not by the vehicle leaving.
        if (ev_ok) begin
          state_d  = StAbierto;
          fallos_d = 2'd0;
        end else if (ev_mal) begin
          fallos_d = MaxFallos;
        end
      end
      StAbierto: begin
        if (Termino) begin
          state_d = Vehiculo ? StBloqueo : StIdle;
          if (!Vehiculo) fallos_d = 2'd0;
        end
      end
      StBloqueo: begin
        if (ev_ok) begin
          state_d  = StIdle;
          fallos_d = 2'd0;
        end
      end
      default: begin
        state_d  = StIdle;
        fallos_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      fallos_q  <= 2'd0;
      salidas_q <= decodifica(StIdle);
    end else begin
      state_q   <= state_d;
      fallos_q  <= fallos_d;
      salidas_q <= decodifica(state_d);
    end
  end

  assign Cerrado = salidas_q.cerrado;
  assign Abierto = salidas_q.abierto;
  assign Alarma  = salidas_q.alarma;
  assign Bloqueo = salidas_q.bloqueo;

endmodule

// File: tb/tb_controlador_compuerta.sv
// Self-checking bench for the parking-gate controller: directed scenarios plus a
// randomized run, all compared against a behavioural gate model.
module tb_controlador_compuerta;

  logic       Clk = 1'b1;
  logic       Reset;
  logic       Vehiculo, Termino;
  logic [7:0] Pin;
  logic       Cerrado, Abierto, Alarma, Bloqueo;

  int n_checks = 0;
  int n_err    = 0;

  controlador_compuerta dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Vehiculo(Vehiculo),
    .Termino (Termino),
    .Pin     (Pin),
    .Cerrado (Cerrado),
    .Abierto (Abierto),
    .Alarma  (Alarma),
    .Bloqueo (Bloqueo)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: gate mode, wrong-attempt tally and last keypad value.
  localparam int MIdle = 0, MWait = 1, MOpen = 2, MAlarm = 3, MBlock = 4;
  localparam int MaxTries = 3;
  int         m_mode;
  int         m_tries;
  logic [7:0] m_prev;
  logic [3:0] exp_out;  // {Cerrado, Abierto, Alarma, Bloqueo}
  logic [3:0] obs;

  function automatic logic [3:0] mode_outputs(int mode);
    logic [3:0] tbl [5];
    tbl = '{4'b1000, 4'b1000, 4'b0100, 4'b1010, 4'b1011};
    return tbl[mode];
  endfunction

  task automatic model_reset();
    m_mode  = MIdle;
    m_tries = 0;
    m_prev  = 8'h00;
    exp_out = mode_outputs(m_mode);
  endtask

  task automatic model_step(input logic v, input logic t, input logic [7:0] p);
    bit entry, good, bad;
    entry  = (p != 8'h00) && (m_prev == 8'h00);
    good   = entry && (p == 8'h08);
    bad    = entry && !good;
    m_prev = p;
    if (m_mode == MIdle) begin
      if (v) m_mode = MWait;
    end else if (m_mode == MWait) begin
      if (good) m_mode = MOpen;
      else if (bad) begin
        m_tries++;
        if (m_tries >= MaxTries) m_mode = MAlarm;
      end else if (!v) m_mode = MIdle;
    end else if (m_mode == MAlarm) begin
      if (good) m_mode = MOpen;
    end else if (m_mode == MOpen) begin
      if (t) m_mode = v ? MBlock : MIdle;
    end else if (m_mode == MBlock) begin
      if (good) m_mode = MIdle;
    end
    if (m_mode == MIdle || m_mode == MOpen) m_tries = 0;
    exp_out = mode_outputs(m_mode);
  endtask

  // Drive at the falling edge, capture 1 ns after the rising edge, return on the falling edge.
  task automatic step(input logic v, input logic t, input logic [7:0] p);
    Vehiculo = v;
    Termino  = t;
    Pin      = p;
    @(posedge Clk);
    model_step(v, t, p);
    #1;
    obs = {Cerrado, Abierto, Alarma, Bloqueo};
    @(negedge Clk);
  endtask

  task automatic apply_reset();
    Vehiculo = 1'b0;
    Termino  = 1'b0;
    Pin      = 8'h00;
    Reset    = 1'b0;
    #2;
    Reset = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Vehiculo = 1'b0; Termino = 1'b0; Pin = 8'h00;
    #5 Reset = 1'b0;
    #1;
    obs = {Cerrado, Abierto, Alarma, Bloqueo};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_err++; $display("FAIL reset_async: got %b expected 1000", obs);
    end
    #9 Reset = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    obs = {Cerrado, Abierto, Alarma, Bloqueo};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_err++; $display("FAIL reset_release: got %b expected 1000", obs);
    end
    @(negedge Clk);
    step(1'b1, 1'b0, 8'h00);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL reset_to_wait: got %b expected 1000", obs);
    end
  endtask

  task automatic test_wrong_pins();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 8'hFF);
      n_checks++;
      if (obs !== exp_out || obs[1] !== (k >= 2) || obs[3] !== 1'b1) begin
        n_err++; $display("FAIL wrong_pin_%0d: got %b expected %b", k, obs, exp_out);
      end
      step(1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic test_held_pin();
    apply_reset();
    step(1'b1, 1'b0, 8'h00);
    repeat (5) step(1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hFF);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL held_pin_second: got %b expected 1000", obs);
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hFF);
    n_checks++;
    if (obs !== 4'b1010 || obs !== exp_out) begin
      n_err++; $display("FAIL held_pin_third: got %b expected 1010", obs);
    end
    step(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (obs !== 4'b1010) begin
      n_err++; $display("FAIL alarm_sticky: got %b expected 1010", obs);
    end
  endtask

  task automatic test_open_from_alarm();
    step(1'b1, 1'b0, 8'h08);
    n_checks++;
    if (obs !== 4'b0100 || obs !== exp_out) begin
      n_err++; $display("FAIL open_from_alarm: got %b expected 0100", obs);
    end
    step(1'b0, 1'b1, 8'h00);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL pass_to_idle: got %b expected 1000", obs);
    end
  endtask

  task automatic test_tailgate();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h08);
    step(1'b1, 1'b1, 8'h00);
    n_checks++;
    if (obs !== 4'b1011 || obs !== exp_out) begin
      n_err++; $display("FAIL tailgate_block: got %b expected 1011", obs);
    end
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (obs !== 4'b1011) begin
      n_err++; $display("FAIL block_ignores_bad: got %b expected 1011", obs);
    end
    step(1'b0, 1'b0, 8'h08);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL block_clear: got %b expected 1000", obs);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h08);
    n_checks++;
    if (obs !== 4'b0100 || obs !== exp_out) begin
      n_err++; $display("FAIL pin_beats_leave: got %b expected 0100", obs);
    end
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h08);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL idle_ignores_pin: got %b expected 1000", obs);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 8'h00);
    repeat (3) begin
      step(1'b1, 1'b0, 8'hFF);
      step(1'b1, 1'b0, 8'h00);
    end
    n_checks++;
    if (obs !== 4'b1010 || obs !== exp_out) begin
      n_err++; $display("FAIL reach_alarm: got %b expected 1010", obs);
    end
    #2 Reset = 1'b0;
    #1;
    obs = {Cerrado, Abierto, Alarma, Bloqueo};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_err++; $display("FAIL reset_mid_async: got %b expected 1000", obs);
    end
    #1 Reset = 1'b1;
    model_reset();
    @(negedge Clk);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hFF);
    n_checks++;
    if (obs !== 4'b1000 || obs !== exp_out) begin
      n_err++; $display("FAIL reset_clears_tries: got %b expected 1000", obs);
    end
  endtask

  task automatic test_random();
    logic       v, t;
    logic [7:0] p;
    int         r;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      p = (r < 4) ? 8'h00 : (r < 6) ? 8'h08 : (r < 8) ? 8'hFF : 8'($urandom);
      step(v, t, p);
      n_checks++;
      if (obs !== exp_out || (obs[3] && obs[2]) || (obs[0] && !obs[1])) begin
        n_err++; $display("FAIL random_%0d: got %b expected %b", i, obs, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrong_pins();
    test_held_pin();
    test_open_from_alarm();
    test_tailgate();
    test_simultaneous();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
